// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer:
// opcodes, ALU operation codes and controller state encodings.
package isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_BEQZ = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_PASSB = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_IR_LD  = 4'd2,
        S_DECODE = 4'd3,
        S_OPA    = 4'd4,
        S_OPB    = 4'd5,
        S_EXEC   = 4'd6,
        S_WB     = 4'd7,
        S_MEM    = 4'd8,
        S_BRANCH = 4'd9,
        S_DONE   = 4'd10,
        S_ERR    = 4'd11,
        S_HALTED = 4'd12
    } state_e;

endpackage

// File: rtl/seq_wait_timer.sv
// Memory wait counter; held at zero outside a wait state, so every
// FETCH/MEM visit starts counting from zero.
module seq_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = 8'd0;
        if (active && !ready) begin
            count_d = count_q + 8'd1;
        end else if (active) begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout = active && (count_q == LIMIT);

endmodule

// File: rtl/instr_seq_ctrl.sv
// One-instruction-per-start sequencer: fetch, decode and drive the
// one-hot datapath strobes of the single-bus machine.
module instr_seq_ctrl
    import isa_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    input  logic               zero_flag,
    output logic               pc_out,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_load,
    output logic               alu_a,
    output logic               alu_b,
    output logic               reg_out,
    output logic               imm_out,
    output logic               alu_in_en,
    output logic               alu_out_en,
    output logic               reg_dest,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [1:0]         alu_op,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic               bus_err
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               taken_q, taken_d;
    logic               bus_q, bus_d;
    logic [3:0]         opc;
    logic [1:0]         aop;
    logic               waiting;
    logic               tmo;
    logic               ir_unused;

    assign opc       = ir_q[INSTR_W-1 -: 4];
    assign ir_unused = ^ir_q[INSTR_W-5:0];
    assign aop       = (opc == OP_SUB) ? ALU_SUB : ALU_ADD;
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);

    seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (waiting),
        .ready   (mem_ready),
        .timeout (tmo)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        taken_d = taken_q;
        bus_d   = bus_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_IR_LD;
                    ir_d    = mem_rdata;
                end else if (tmo) begin
                    state_d = S_ERR;
                    bus_d   = 1'b1;
                end
            end
            S_IR_LD:  state_d = S_DECODE;
            S_DECODE: begin
                bus_d   = 1'b0;
                taken_d = 1'b0;
                case (opc)
                    OP_NOP:                  state_d = S_DONE;
                    OP_ADD, OP_SUB, OP_ADDI: state_d = S_OPA;
                    OP_LD, OP_ST:            state_d = S_MEM;
                    OP_BEQZ:                 state_d = S_BRANCH;
                    OP_HALT:                 state_d = S_HALTED;
                    default:                 state_d = S_ERR;
                endcase
            end
            S_OPA:    state_d = S_OPB;
            S_OPB:    state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_DONE;
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_ERR;
                    bus_d   = 1'b1;
                end
            end
            S_BRANCH: begin
                taken_d = zero_flag;
                state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            taken_q <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            taken_q <= taken_d;
            bus_q   <= bus_d;
        end
    end

    always_comb begin
        pc_out     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_load    = 1'b0;
        alu_a      = 1'b0;
        alu_b      = 1'b0;
        reg_out    = 1'b0;
        imm_out    = 1'b0;
        alu_in_en  = 1'b0;
        alu_out_en = 1'b0;
        reg_dest   = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_op     = ALU_ADD;
        done       = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
        case (state_q)
            S_FETCH: begin
                pc_out = 1'b1;
                mem_rd = 1'b1;
            end
            S_IR_LD:  ir_load = 1'b1;
            S_OPA: begin
                reg_out = 1'b1;
                alu_a   = 1'b1;
            end
            S_OPB: begin
                alu_b   = 1'b1;
                imm_out = (opc == OP_ADDI);
                reg_out = (opc != OP_ADDI);
            end
            S_EXEC: begin
                alu_in_en  = 1'b1;
                alu_out_en = 1'b1;
                alu_op     = aop;
            end
            S_WB: begin
                reg_dest   = 1'b1;
                alu_out_en = 1'b1;
                alu_op     = aop;
            end
            S_MEM: begin
                imm_out  = 1'b1;
                mem_rd   = (opc == OP_LD);
                reg_dest = (opc == OP_LD);
                mem_wr   = (opc != OP_LD);
                reg_out  = (opc != OP_LD);
            end
            // Branch target comes straight off the immediate bus
            S_BRANCH: begin
                pc_load = zero_flag;
                imm_out = zero_flag;
            end
            S_DONE: begin
                done   = 1'b1;
                pc_inc = !taken_q;
            end
            S_ERR: begin
                bus_err = bus_q;
                illegal = !bus_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Randomized bench for instr_seq_ctrl; expected strobes per cycle come
// from a phase-level model of each instruction class.
module tb_instr_seq_ctrl;

    localparam int TMO = 15;

    localparam logic [18:0] B_PC_OUT  = 19'd1 << 18;
    localparam logic [18:0] B_MEM_RD  = 19'd1 << 17;
    localparam logic [18:0] B_MEM_WR  = 19'd1 << 16;
    localparam logic [18:0] B_IR_LOAD = 19'd1 << 15;
    localparam logic [18:0] B_ALU_A   = 19'd1 << 14;
    localparam logic [18:0] B_ALU_B   = 19'd1 << 13;
    localparam logic [18:0] B_REG_OUT = 19'd1 << 12;
    localparam logic [18:0] B_IMM     = 19'd1 << 11;
    localparam logic [18:0] B_ALU_IN  = 19'd1 << 10;
    localparam logic [18:0] B_ALU_OUT = 19'd1 << 9;
    localparam logic [18:0] B_REG_DST = 19'd1 << 8;
    localparam logic [18:0] B_PC_INC  = 19'd1 << 7;
    localparam logic [18:0] B_PC_LOAD = 19'd1 << 6;
    localparam logic [18:0] B_SUB     = 19'd1 << 4;
    localparam logic [18:0] B_BUSY    = 19'd1 << 3;
    localparam logic [18:0] B_DONE    = 19'd1 << 2;
    localparam logic [18:0] B_ILLEGAL = 19'd1 << 1;
    localparam logic [18:0] B_BUS_ERR = 19'd1;

    logic        clk = 1'b0;
    logic        reset, start, mem_ready, zero_flag;
    logic [15:0] mem_rdata;
    logic        pc_out, mem_rd, mem_wr, ir_load, alu_a, alu_b;
    logic        reg_out, imm_out, alu_in_en, alu_out_en, reg_dest;
    logic        pc_inc, pc_load, busy, done, illegal, bus_err;
    logic [1:0]  alu_op;
    logic [18:0] obs;

    int checks = 0;
    int errors = 0;

    logic [18:0] eq[$];
    bit          rq[$];
    bit          sq[$];

    instr_seq_ctrl #(.INSTR_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .zero_flag(zero_flag),
        .pc_out(pc_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_load(ir_load), .alu_a(alu_a), .alu_b(alu_b),
        .reg_out(reg_out), .imm_out(imm_out), .alu_in_en(alu_in_en),
        .alu_out_en(alu_out_en), .reg_dest(reg_dest), .pc_inc(pc_inc),
        .pc_load(pc_load), .alu_op(alu_op), .busy(busy), .done(done),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign obs = {pc_out, mem_rd, mem_wr, ir_load, alu_a, alu_b, reg_out,
                  imm_out, alu_in_en, alu_out_en, reg_dest, pc_inc,
                  pc_load, alu_op, busy, done, illegal, bus_err};

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic [18:0] e, bit r, bit s);
        eq.push_back(e);
        rq.push_back(r);
        sq.push_back(s);
    endfunction

    // A memory wait: d cycles without ready, then ready, unless d
    // exceeds the timeout budget (TMO+1 request cycles in total).
    function automatic bit wait_phase(int d, logic [18:0] e);
        if (d > TMO) begin
            for (int i = 0; i <= TMO; i++) push(e, 1'b0, rb());
            return 1'b0;
        end
        for (int i = 0; i < d; i++) push(e, 1'b0, rb());
        push(e, 1'b1, rb());
        return 1'b1;
    endfunction

    function automatic void build(logic [15:0] ins, int fd, int md, bit z);
        logic [3:0]  op;
        logic [18:0] ao;
        logic [18:0] mw;
        op = ins[15:12];
        eq.delete();
        rq.delete();
        sq.delete();
        push('0, rb(), 1'b1);
        if (!wait_phase(fd, B_PC_OUT | B_MEM_RD | B_BUSY)) begin
            push(B_BUSY | B_BUS_ERR, rb(), rb());
            push('0, rb(), 1'b0);
            return;
        end
        push(B_IR_LOAD | B_BUSY, rb(), rb());
        push(B_BUSY, rb(), rb());
        if (op == 4'd7) begin
            for (int i = 0; i < 5; i++) push('0, rb(), rb());
            return;
        end
        if (op >= 4'd8) begin
            push(B_BUSY | B_ILLEGAL, rb(), rb());
            push('0, rb(), 1'b0);
            return;
        end
        if (op >= 4'd1 && op <= 4'd3) begin
            ao = (op == 4'd2) ? B_SUB : '0;
            push(B_REG_OUT | B_ALU_A | B_BUSY, rb(), rb());
            push(B_ALU_B | B_BUSY | ((op == 4'd3) ? B_IMM : B_REG_OUT),
                 rb(), rb());
            push(B_ALU_IN | B_ALU_OUT | ao | B_BUSY, rb(), rb());
            push(B_REG_DST | B_ALU_OUT | ao | B_BUSY, rb(), rb());
        end else if (op == 4'd4 || op == 4'd5) begin
            mw = (op == 4'd4) ? (B_MEM_RD | B_REG_DST)
                              : (B_MEM_WR | B_REG_OUT);
            if (!wait_phase(md, B_IMM | B_BUSY | mw)) begin
                push(B_BUSY | B_BUS_ERR, rb(), rb());
                push('0, rb(), 1'b0);
                return;
            end
        end else if (op == 4'd6) begin
            push(B_BUSY | (z ? (B_PC_LOAD | B_IMM) : '0), rb(), rb());
        end
        push(B_BUSY | B_DONE | ((op == 4'd6 && z) ? '0 : B_PC_INC),
             rb(), rb());
        push('0, rb(), 1'b0);
    endfunction

    task automatic check(input logic [18:0] e, input string tag);
        checks++;
        assert (obs === e)
        else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, e);
        end
    endtask

    task automatic run(input logic [15:0] ins, input int fd, input int md,
                       input bit z, input int abort_at);
        build(ins, fd, md, z);
        zero_flag = z;
        mem_rdata = ins;
        for (int i = 0; i < eq.size(); i++) begin
            @(negedge clk);
            start     = sq[i];
            mem_ready = rq[i];
            reset     = (i == abort_at);
            #1;
            check(eq[i], $sformatf("ins%04h_fd%0d_md%0d_z%0d_c%0d",
                                   ins, fd, md, z, i));
            if (i == abort_at) begin
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                #1;
                check('0, $sformatf("ins%04h_after_reset", ins));
                break;
            end
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] ins;
        int          fd, md;
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        #1;
        check('0, "reset_state");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check('0, "idle_after_reset");

        run(16'h3005, 0, 0, 1'b0, -1);
        run(16'h4010, 0, 3, 1'b0, -1);
        run(16'h6004, 0, 0, 1'b1, -1);
        run(16'h6004, 0, 0, 1'b0, -1);
        run(16'hA000, 0, 0, 1'b0, -1);
        run(16'h1000, 16, 0, 1'b0, -1);
        run(16'h1000, 15, 0, 1'b0, -1);
        run(16'h5022, 2, 16, 1'b0, -1);
        run(16'h4022, 1, 15, 1'b0, -1);
        run(16'h2345, 1, 0, 1'b0, -1);
        run(16'h5001, 0, 0, 1'b0, -1);
        run(16'h0000, 0, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd7) op = 4'hB;
            ins = {op, 12'($urandom)};
            fd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17))
                                             : int'($urandom_range(0, 3));
            md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17))
                                             : int'($urandom_range(0, 4));
            run(ins, fd, md, rb(), -1);
        end

        run(16'h1234, 0, 0, 1'b0, 6);
        run(16'h2111, 0, 0, 1'b0, -1);

        run(16'h7000, 0, 0, 1'b0, -1);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        #1;
        check('0, "halted_reset_cycle");
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        check('0, "halted_released");
        run(16'h0000, 0, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
